// File: rtl/mem_access_if.sv
// mem_access_if: data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata);
    modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM stage issuing LW/LB/SW over a req/ack bus with timeout abort.
// Optional macro MEM_ALIGN_CHECK_EN traps misaligned LW/SW instead of issuing them.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          mem_op,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_data,
    input  logic [4:0]          wb_write_reg,
    input  logic [31:0]         wb_write_data,
    input  logic                wb_we,
    output logic                stall_req,
    mem_access_if.master        dmem,
    output logic                wb_we_o,
    output logic [4:0]          wb_write_reg_o,
    output logic [31:0]         wb_write_data_o,
    output logic                bus_err,
    output logic                misalign
);
    localparam logic [3:0] MEM_NOP_OP = 4'd0;
    localparam logic [3:0] MEM_LW_OP  = 4'd1;
    localparam logic [3:0] MEM_SW_OP  = 4'd2;
    localparam logic [3:0] MEM_LB_OP  = 4'd3;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, we_q, wb_we_q, bus_err_q, misalign_q;
    logic [31:0]   addr_q, wdata_q, wb_data_q;
    logic [4:0]    wb_reg_q;
    logic          is_nop, is_ld, is_mem, mis, timeout;
    logic [7:0]    byte_sel;
    logic [31:0]   ld_data;

    always_comb begin
        is_nop   = mem_op == MEM_NOP_OP;
        is_ld    = mem_op == MEM_LW_OP || mem_op == MEM_LB_OP;
        is_mem   = !is_nop && (is_ld || mem_op == MEM_SW_OP);
`ifdef MEM_ALIGN_CHECK_EN
        mis      = (mem_op == MEM_LW_OP || mem_op == MEM_SW_OP) && mem_addr[1:0] != 2'b00;
`else
        mis      = 1'b0;
`endif
        cnt_d    = cnt_q + 1'b1;
        timeout  = cnt_d == CW'(TIMEOUT_CYCLES);
        byte_sel = dmem.dmem_rdata[{mem_addr[1:0], 3'b000} +: 8];
        ld_data  = mem_op == MEM_LB_OP ? {{24{byte_sel[7]}}, byte_sel} : dmem.dmem_rdata;
        stall_req = state_q == BUSY ? ~dmem.dmem_ack : is_mem && !mis;
    end

    // Upstream holds mem_op/mem_addr/wb_* stable while stalled, so they are read live at ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_we_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            if (state_q == IDLE) begin
                if (is_mem && !mis) begin
                    state_q <= BUSY;
                    cnt_q   <= '0;
                    req_q   <= 1'b1;
                    we_q    <= mem_op == MEM_SW_OP;
                    addr_q  <= {mem_addr[31:2], 2'b00};
                    wdata_q <= mem_data;
                    wb_we_q <= 1'b0;
                end else begin
                    misalign_q <= mis;
                    wb_we_q    <= mis ? 1'b0 : wb_we;
                    wb_reg_q   <= wb_write_reg;
                    wb_data_q  <= wb_write_data;
                end
            end else if (dmem.dmem_ack) begin
                state_q   <= IDLE;
                req_q     <= 1'b0;
                wb_we_q   <= wb_we;
                wb_reg_q  <= wb_write_reg;
                wb_data_q <= mem_op == MEM_SW_OP ? 32'd0 : ld_data;
            end else if (timeout) begin
                state_q   <= IDLE;
                req_q     <= 1'b0;
                bus_err_q <= 1'b1;
                wb_we_q   <= is_ld && wb_we;
                wb_reg_q  <= wb_write_reg;
                wb_data_q <= '0;
            end else begin
                cnt_q   <= cnt_d;
                wb_we_q <= 1'b0;
            end
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_we_o         = wb_we_q;
    assign wb_write_reg_o  = wb_reg_q;
    assign wb_write_data_o = wb_data_q;
    assign bus_err         = bus_err_q;
    assign misalign        = misalign_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of mem_access with TIMEOUT_CYCLES=4; misalign checks follow MEM_ALIGN_CHECK_EN.
module tb_mem_access;
    localparam logic [3:0] NOP = 4'd0, LW = 4'd1, SW = 4'd2, LB = 4'd3;

    logic        clk, rst;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, mem_data, wb_write_data;
    logic [4:0]  wb_write_reg;
    logic        wb_we, stall_req, wb_we_o, bus_err, misalign;
    logic [4:0]  wb_write_reg_o;
    logic [31:0] wb_write_data_o;
    int          n_run, n_fail;

    mem_access_if bus ();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_op(mem_op), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .wb_we(wb_we),
        .stall_req(stall_req), .dmem(bus.master), .wb_we_o(wb_we_o),
        .wb_write_reg_o(wb_write_reg_o), .wb_write_data_o(wb_write_data_o),
        .bus_err(bus_err), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic [4:0] r, input logic [31:0] wd);
        mem_op = o; mem_addr = a; mem_data = d; wb_we = we; wb_write_reg = r; wb_write_data = wd;
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        rst = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        op(NOP, 0, 0, 0, 0, 0);
        #12;
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_we", bus.dmem_we, 0);
        chk("rst_addr", bus.dmem_addr, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_wb_we", wb_we_o, 0);
        chk("rst_wb_reg", wb_write_reg_o, 0);
        chk("rst_wb_data", wb_write_data_o, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_stall", stall_req, 0);
        tick();
        rst = 1'b1;
        // passthrough
        op(NOP, 0, 0, 1, 5, 32'h1234);
        #1 chk("pt_stall", stall_req, 0);
        tick();
        chk("pt_we", wb_we_o, 1);
        chk("pt_reg", wb_write_reg_o, 5);
        chk("pt_data", wb_write_data_o, 32'h1234);
        chk("pt_stall2", stall_req, 0);
        // LW, ack in first BUSY cycle
        op(LW, 32'h100, 0, 1, 7, 32'hDEAD);
        #1 chk("lw_stall_issue", stall_req, 1);
        tick();
        chk("lw_req", bus.dmem_req, 1);
        chk("lw_we", bus.dmem_we, 0);
        chk("lw_addr", bus.dmem_addr, 32'h100);
        chk("lw_bubble", wb_we_o, 0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
        #1 chk("lw_stall_ack", stall_req, 0);
        tick();
        bus.dmem_ack = 1'b0;
        chk("lw_req_drop", bus.dmem_req, 0);
        chk("lw_wb_we", wb_we_o, 1);
        chk("lw_wb_reg", wb_write_reg_o, 7);
        chk("lw_wb_data", wb_write_data_o, 32'hCAFEF00D);
        op(NOP, 0, 0, 0, 0, 0);
        #1 chk("lw_stall_after", stall_req, 0);
        tick();
        // LB byte 3 (negative)
        op(LB, 32'h203, 0, 1, 9, 0);
        tick();
        chk("lb3_addr", bus.dmem_addr, 32'h200);
        chk("lb3_we", bus.dmem_we, 0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80112233;
        tick();
        bus.dmem_ack = 1'b0;
        chk("lb3_data", wb_write_data_o, 32'hFFFFFF80);
        chk("lb3_wb_we", wb_we_o, 1);
        chk("lb3_reg", wb_write_reg_o, 9);
        // LB byte 1 (positive), back-to-back with no dead cycle
        op(LB, 32'h201, 0, 1, 10, 0);
        #1 chk("lb1_stall", stall_req, 1);
        tick();
        chk("lb1_req", bus.dmem_req, 1);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        chk("lb1_data", wb_write_data_o, 32'h00000022);
        // SW with ack after 3 waiting BUSY cycles
        op(SW, 32'h40, 32'hA5A5A5A5, 0, 3, 0);
        #1 chk("sw_stall_issue", stall_req, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sw_stall_busy", stall_req, 1);
            chk("sw_req", bus.dmem_req, 1);
            chk("sw_we", bus.dmem_we, 1);
            chk("sw_addr", bus.dmem_addr, 32'h40);
            chk("sw_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
            chk("sw_bubble", wb_we_o, 0);
            tick();
        end
        bus.dmem_ack = 1'b1;
        #1 chk("sw_stall_ack", stall_req, 0);
        tick();
        bus.dmem_ack = 1'b0;
        chk("sw_req_drop", bus.dmem_req, 0);
        chk("sw_wb_we", wb_we_o, 0);
        chk("sw_wb_data", wb_write_data_o, 0);
        chk("sw_bus_err", bus_err, 0);
        // LW timeout after 4 BUSY cycles
        op(LW, 32'h80, 0, 1, 11, 32'h55);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("to_req_hold", bus.dmem_req, 1);
            chk("to_no_err", bus_err, 0);
            tick();
        end
        tick();
        chk("to_bus_err", bus_err, 1);
        chk("to_req_drop", bus.dmem_req, 0);
        chk("to_wb_we", wb_we_o, 1);
        chk("to_wb_reg", wb_write_reg_o, 11);
        chk("to_wb_data", wb_write_data_o, 0);
        op(NOP, 0, 0, 0, 0, 0);
        tick();
        chk("to_err_pulse", bus_err, 0);
        chk("to_nop_we", wb_we_o, 0);
        // ack coincides with timeout: ack wins
        op(LW, 32'h10, 0, 1, 12, 0);
        tick();
        repeat (3) tick();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h13572468;
        tick();
        bus.dmem_ack = 1'b0;
        chk("race_bus_err", bus_err, 0);
        chk("race_data", wb_write_data_o, 32'h13572468);
        chk("race_wb_we", wb_we_o, 1);
        // ack in IDLE is ignored
        op(NOP, 0, 0, 1, 1, 32'h77);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
        tick();
        bus.dmem_ack = 1'b0;
        chk("idle_ack_req", bus.dmem_req, 0);
        chk("idle_ack_data", wb_write_data_o, 32'h77);
        // misaligned LW
        op(LW, 32'h102, 0, 1, 13, 0);
`ifdef MEM_ALIGN_CHECK_EN
        #1 chk("mis_stall", stall_req, 0);
        tick();
        chk("mis_pulse", misalign, 1);
        chk("mis_req", bus.dmem_req, 0);
        chk("mis_wb_we", wb_we_o, 0);
        op(NOP, 0, 0, 0, 0, 0);
        tick();
        chk("mis_pulse_end", misalign, 0);
`else
        #1 chk("mis_stall", stall_req, 1);
        tick();
        chk("mis_req", bus.dmem_req, 1);
        chk("mis_addr", bus.dmem_addr, 32'h100);
        chk("mis_tied", misalign, 0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0BADF00D;
        tick();
        bus.dmem_ack = 1'b0;
        chk("mis_data", wb_write_data_o, 32'h0BADF00D);
        op(NOP, 0, 0, 0, 0, 0);
        tick();
`endif
        // reset asserted mid-BUSY
        op(LW, 32'h300, 0, 1, 14, 0);
        tick();
        chk("mrst_req_before", bus.dmem_req, 1);
        #2 rst = 1'b0;
        #1 chk("mrst_req", bus.dmem_req, 0);
        chk("mrst_wb_we", wb_we_o, 0);
        op(NOP, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_wb_we_after", wb_we_o, 0);
        chk("mrst_req_after", bus.dmem_req, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
